delay_timer: RTL and testbench
==============================

DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the counter and delay-value width per channel.
REQ-002 Parameter CHANNELS, default 2, SHALL set the number of independent timer channels.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-005 start  in  CHANNELS  SHALL be a per-channel request to (re)start a delay.
REQ-006 delay  in  CHANNELS*WIDTH  SHALL carry per-channel delay values; channel c uses bits [c*WIDTH +: WIDTH].
REQ-007 abort  in  CHANNELS  SHALL be a per-channel cancel request.
REQ-008 periodic  in  CHANNELS  SHALL be a per-channel auto-reload request, effective only per REQ-030.
REQ-009 hold  in  1  SHALL be a global freeze of counting for all channels.
REQ-010 busy  out  CHANNELS  SHALL be high while the channel is in state RUN.
REQ-011 pass  out  CHANNELS  SHALL be a one-cycle expiry pulse per channel.
REQ-012 count  out  CHANNELS*WIDTH  SHALL expose each channel's current count, same packing as delay.

Function
REQ-013 Each channel SHALL run an independent two-state FSM, IDLE and RUN, with a latched limit register of WIDTH bits.
REQ-014 IDLE and start=1: limit <= delay[c], count <= 0, go to RUN.
REQ-015 RUN, hold=0, count != limit: count <= count+1; pass <= 0.
REQ-016 RUN, hold=0, count == limit: pass <= 1 for exactly one cycle; count <= 0; go to IDLE (one-shot) or stay in RUN (auto-reload, REQ-030).
REQ-017 Latency: start sampled at edge E0 with value D SHALL produce pass high during the cycle after edge E0+D+1; D=0 gives pass after E0+1.
REQ-018 delay changes while in RUN SHALL be ignored; only the value latched at start applies.
REQ-019 start while in RUN SHALL restart: limit reloaded, count <= 0, no pass emitted that cycle even if count == limit.
REQ-020 abort while in RUN: go to IDLE, count <= 0, pass <= 0; abort in IDLE has no effect.
REQ-021 abort and start in the same cycle: abort SHALL win; the channel ends in IDLE with count 0.
REQ-022 hold=1: count, limit and state frozen and pass <= 0; start and abort SHALL still take effect.
REQ-023 Count SHALL never exceed limit; no wrap-around occurs for any D up to 2^WIDTH-1.
REQ-024 pass SHALL be deasserted in every cycle not covered by REQ-016.
REQ-025 Channels SHALL not interact except through the shared hold input.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force all channels to IDLE, count=0, limit=0, pass=0, busy=0.
REQ-027 Reset SHALL override start, abort and hold in the same cycle.
REQ-028 Reset during RUN SHALL discard the pending expiry; no pass is emitted afterwards without a new start.
REQ-029 The first start is accepted at the first edge with rst_n=1.

Configuration
REQ-030 With DELAY_TIMER_AUTORELOAD_EN defined, a channel with periodic[c]=1 at expiry SHALL stay in RUN with count <= 0, giving pass every D+1 cycles until abort, or until periodic[c]=0 at an expiry.
REQ-031 Without DELAY_TIMER_AUTORELOAD_EN, the periodic input SHALL be ignored and every expiry returns the channel to IDLE.

Verification
REQ-032 Reset; ch0 start, delay=3 -> busy[0] high 4 cycles, count 0,1,2,3, pass[0] pulses once after E0+4, then IDLE.
REQ-033 ch0 delay=0 start -> pass[0] high the cycle after E0+1 for one cycle; ch1 delay=7 concurrently -> pass[1] after E0+8, independent.
REQ-034 ch0 delay=5; hold=1 for 3 cycles at count=2 -> count frozen at 2; pass[0] after E0+9.
REQ-035 ch0 delay=4; restart at count=2 with delay=1 -> count 0,1, pass after restart+2; abort+start same cycle -> IDLE, no pass.
REQ-036 Macro defined, periodic[0]=1, delay=2 -> pass[0] every 3 cycles; macro undefined -> single pulse only.
REQ-037 rst_n=0 mid-RUN at count=3 -> all outputs 0 next cycle; no later pass without a new start.

Source files
------------

// File: rtl/delay_timer.sv
// delay_timer -- bank of independent one-shot / auto-reload delay timers.
//
// Each channel is a two-state FSM (IDLE, RUN). A start latches the channel's
// delay value D into a private limit register and clears the count. While
// running, the count advances once per unfrozen cycle. When it reaches the
// limit, the channel emits a one-cycle pass pulse and clears the count. The
// pulse therefore appears D+1 unfrozen cycles after the start.
//
// Optional feature (compile-time macro DELAY_TIMER_AUTORELOAD_EN):
//   When defined, a channel whose periodic bit is set at expiry stays in RUN
//   and starts the next period. When undefined, periodic is ignored and
//   every expiry returns the channel to IDLE.
//
// Parameters:
//   WIDTH     counter / delay width per channel
//   CHANNELS  number of independent channels
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     per-channel (re)start request
//   delay     per-channel delay values; channel c uses [c*WIDTH +: WIDTH]
//   abort     per-channel cancel; takes priority over start
//   periodic  per-channel auto-reload request (macro-dependent)
//   hold      global freeze of counting; start/abort still act
//   busy      per-channel, high while in RUN
//   pass      per-channel one-cycle expiry pulse (registered)
//   count     per-channel current count, same packing as delay
module delay_timer #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*WIDTH-1:0] delay,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic                      hold,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       pass,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q [CHANNELS];
  state_t                state_d [CHANNELS];
  logic [WIDTH-1:0]      limit_q [CHANNELS];
  logic [WIDTH-1:0]      limit_d [CHANNELS];
  logic [WIDTH-1:0]      cnt_q   [CHANNELS];
  logic [WIDTH-1:0]      cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]   pass_q;
  logic [CHANNELS-1:0]   pass_d;
  logic [CHANNELS-1:0]   reload;

`ifdef DELAY_TIMER_AUTORELOAD_EN
  assign reload = periodic;
`else
  // periodic has no function in this build; fold it into a sink so the
  // port stays in the interface without an undriven/unused warning.
  logic unused_periodic;
  assign unused_periodic = ^periodic;
  assign reload          = '0;
`endif

  // Next-state logic. Per-channel priority: abort > start > hold > counting.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      limit_d[c] = limit_q[c];
      cnt_d[c]   = cnt_q[c];
      pass_d[c]  = 1'b0;

      if (abort[c]) begin
        // In IDLE the count is already zero, so this is a no-op there.
        state_d[c] = IDLE;
        cnt_d[c]   = '0;
      end else if (start[c]) begin
        // Restart from RUN suppresses any expiry due this cycle.
        state_d[c] = RUN;
        limit_d[c] = delay[c*WIDTH +: WIDTH];
        cnt_d[c]   = '0;
      end else if (state_q[c] == RUN && !hold) begin
        if (cnt_q[c] != limit_q[c]) begin
          cnt_d[c] = cnt_q[c] + WIDTH'(1);
        end else begin
          pass_d[c] = 1'b1;
          cnt_d[c]  = '0;
          if (!reload[c]) begin
            state_d[c] = IDLE;
          end
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        limit_q[c] <= '0;
        cnt_q[c]   <= '0;
      end
      pass_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        limit_q[c] <= limit_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      pass_q <= pass_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign busy[g]                  = (state_q[g] == RUN);
    assign count[g*WIDTH +: WIDTH]  = cnt_q[g];
  end

  assign pass = pass_q;

endmodule

// File: tb/tb_delay_timer.sv
module tb_delay_timer;
  localparam int W  = 3;
  localparam int CH = 2;

`ifdef DELAY_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   start;
  logic [CH*W-1:0] delay;
  logic [CH-1:0]   abort;
  logic [CH-1:0]   periodic;
  logic            hold;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   pass;
  logic [CH*W-1:0] count;

  always #5 clk = ~clk;

  delay_timer #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .delay(delay), .abort(abort),
    .periodic(periodic), .hold(hold), .busy(busy), .pass(pass), .count(count)
  );

  int total  = 0;
  int passed = 0;
  bit chk_model = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: each running channel owns a number of unfrozen edges
  // still to go before it expires; the visible count is derived from that.
  bit m_act  [CH];
  int m_lim  [CH];
  int m_togo [CH];
  bit m_pass [CH];

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        m_act[c] = 0; m_lim[c] = 0; m_togo[c] = 0; m_pass[c] = 0;
      end else begin
        m_pass[c] = 0;
        if (abort[c]) begin
          m_act[c] = 0;
        end else if (start[c]) begin
          m_act[c]  = 1;
          m_lim[c]  = int'(delay[c*W +: W]);
          m_togo[c] = m_lim[c] + 1;
        end else if (m_act[c] && !hold) begin
          m_togo[c]--;
          if (m_togo[c] == 0) begin
            m_pass[c] = 1;
            if (AR && periodic[c]) m_togo[c] = m_lim[c] + 1;
            else m_act[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_compare(int cyc);
    logic [CH-1:0]   eb, ep;
    logic [CH*W-1:0] ec;
    for (int c = 0; c < CH; c++) begin
      eb[c] = m_act[c];
      ep[c] = m_pass[c];
      ec[c*W +: W] = m_act[c] ? W'(m_lim[c] + 1 - m_togo[c]) : '0;
    end
    check($sformatf("rand%0d.busy", cyc), 32'(busy), 32'(eb));
    check($sformatf("rand%0d.pass", cyc), 32'(pass), 32'(ep));
    check($sformatf("rand%0d.count", cyc), 32'(count), 32'(ec));
  endtask

  int cycle = 0;
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    if (chk_model) model_compare(cycle);
  endtask

  task automatic drive(logic r, logic [CH-1:0] s, logic [CH*W-1:0] d,
                       logic [CH-1:0] a, logic [CH-1:0] p, logic h);
    rst_n = r; start = s; delay = d; abort = a; periodic = p; hold = h;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic            r;
    logic [CH-1:0]   s;
    logic [CH*W-1:0] d;
    logic [CH-1:0]   a;
    logic            h;
    logic [CH-1:0]   eb;
    logic [CH-1:0]   ep;
    logic [CH*W-1:0] ec;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 0; start = 0; delay = 0; abort = 0; periodic = 0; hold = 0;

    // r, start, delay, abort, hold -> busy, pass, count
    vecs.push_back('{1'b0, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b01, 6'o03, 2'b00, 1'b0, 2'b01, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o07, 2'b00, 1'b0, 2'b01, 2'b00, 6'o01});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b01, 2'b00, 6'o02});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b01, 2'b00, 6'o03});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b01, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b11, 1'b0, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b10, 6'o20, 2'b00, 1'b0, 2'b10, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b10, 6'o20, 2'b10, 1'b0, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b01, 6'o02, 2'b00, 1'b1, 2'b01, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b1, 2'b01, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b01, 1'b1, 2'b00, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b11, 6'o70, 2'b00, 1'b0, 2'b11, 2'b00, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b10, 2'b01, 6'o10});
    for (int k = 2; k <= 7; k++)
      vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b10, 2'b00, 6'(k << 3)});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b10, 6'o00});
    vecs.push_back('{1'b1, 2'b00, 6'o00, 2'b00, 1'b0, 2'b00, 2'b00, 6'o00});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].a, 2'b00, vecs[i].h);
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].eb));
      check($sformatf("vec%0d.pass", i), 32'(pass), 32'(vecs[i].ep));
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].ec));
    end

    // Hold: delay 5, freeze three cycles at count 2, expiry after E0+9.
    drive(1, 2'b01, 6'o05, 0, 0, 0);
    idle(2);
    check("hold.pre", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 1);
      check($sformatf("hold.frozen%0d", i), 32'(count), 32'd2);
      check($sformatf("hold.nopass%0d", i), 32'(pass), 32'd0);
    end
    idle(3);
    check("hold.cnt5", 32'(count), 32'd5);
    check("hold.early", 32'(pass), 32'd0);
    idle(1);
    check("hold.pass", 32'(pass), 32'd1);
    check("hold.idle", 32'(busy), 32'd0);

    // Restart: delay 4, restart at count 2 with delay 1.
    drive(1, 2'b01, 6'o04, 0, 0, 0);
    idle(2);
    check("rst.cnt2", 32'(count), 32'd2);
    drive(1, 2'b01, 6'o01, 0, 0, 0);
    check("restart.cnt0", 32'(count), 32'd0);
    check("restart.nopass", 32'(pass), 32'd0);
    drive(1, 0, 6'o07, 0, 0, 0);
    check("restart.cnt1", 32'(count), 32'd1);
    idle(1);
    check("restart.pass", 32'(pass), 32'd1);
    idle(1);

    // Periodic: delay 2, pulses every 3 cycles only with auto-reload.
    drive(1, 2'b01, 6'o02, 0, 2'b01, 0);
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, 0, 0, 2'b01, 0);
      if (k == 3)
        check("per.pass1", 32'(pass), 32'd1);
      if (k == 6)
        check("per.pass2", 32'(pass), AR ? 32'd1 : 32'd0);
    end
    check("per.busy", 32'(busy), AR ? 32'd1 : 32'd0);
    drive(1, 0, 0, 2'b01, 0, 0);
    check("per.abort", 32'(busy), 32'd0);

    // Reset mid-run at count 3, overriding start and hold.
    drive(1, 2'b01, 6'o05, 0, 0, 0);
    idle(3);
    check("rmid.cnt3", 32'(count), 32'd3);
    drive(0, 2'b11, 6'o77, 0, 0, 1);
    check("rmid.busy", 32'(busy), 32'd0);
    check("rmid.count", 32'(count), 32'd0);
    check("rmid.pass", 32'(pass), 32'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check($sformatf("rmid.late%0d", i), 32'(pass), 32'd0);
    end

    // Randomized traffic against the reference model.
    chk_model = 1'b1;
    for (int i = 0; i < 500; i++) begin
      logic [CH-1:0] s, a;
      for (int c = 0; c < CH; c++) begin
        s[c] = ($urandom_range(0, 5) == 0);
        a[c] = ($urandom_range(0, 19) == 0);
      end
      drive(($urandom_range(0, 79) != 0), s, (CH*W)'($urandom), a,
            CH'($urandom), ($urandom_range(0, 4) == 0));
    end
    chk_model = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
